// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode trap entry/exit sequencer; optional TRAP_VECTORED_EN vectors interrupts
module trap_sequencer #(
  parameter int XLEN        = 32,
  parameter int CAUSE_ECALL = 11,
  parameter int CAUSE_MEXT  = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic            is_ecall,
  input  logic            is_mret,
  input  logic            ext_irq,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] mstatus,
  output logic            stall,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] ECALL_CODE = XLEN'(CAUSE_ECALL);
  localparam logic [XLEN-1:0] IRQ_CODE   = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(CAUSE_MEXT);

  typedef enum logic [2:0] {
    S_IDLE, S_EPC, S_CAUSE, S_STAT, S_JUMP, S_RET, S_RJUMP
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] cause_q;
  logic            irq_q;

  logic irq_take;
  logic trigger;
  logic trap_take;

  assign irq_take  = ext_irq & mstatus[3];
  assign trap_take = irq_take | is_ecall;
  assign trigger   = (state == S_IDLE) & instr_valid & (trap_take | is_mret);

  logic [XLEN-1:0] base_pc;
  logic [XLEN-1:0] jump_pc;
  assign base_pc = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Vectored mode only applies to interrupts; mode 2'b1x falls back to direct.
  assign jump_pc = (irq_q && mtvec[1:0] == 2'b01) ? base_pc + XLEN'(4 * CAUSE_MEXT) : base_pc;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];
  assign jump_pc = base_pc;
`endif

  // State register plus trigger-time capture of pc, cause and interrupt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trigger) begin
            pc_q    <= pc;
            irq_q   <= irq_take;
            cause_q <= irq_take ? IRQ_CODE : ECALL_CODE;
            state   <= trap_take ? S_EPC : S_RET;
          end
        end
        S_EPC:   state <= S_CAUSE;
        S_CAUSE: state <= S_STAT;
        S_STAT:  state <= S_JUMP;
        S_JUMP:  state <= S_IDLE;
        S_RET:   state <= S_RJUMP;
        S_RJUMP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode; combinational so reset and the trigger cycle act without delay.
  always_comb begin
    stall       = 1'b0;
    csr_we      = 1'b0;
    csr_waddr   = '0;
    csr_wdata   = '0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    busy        = 1'b0;
    if (!rst) begin
      busy = (state != S_IDLE);
      case (state)
        S_IDLE:  stall = trigger;
        S_EPC: begin
          stall = 1'b1; csr_we = 1'b1; csr_waddr = ADDR_MEPC; csr_wdata = pc_q;
        end
        S_CAUSE: begin
          stall = 1'b1; csr_we = 1'b1; csr_waddr = ADDR_MCAUSE; csr_wdata = cause_q;
        end
        S_STAT: begin
          stall = 1'b1; csr_we = 1'b1; csr_waddr = ADDR_MSTATUS;
          csr_wdata    = mstatus;
          csr_wdata[7] = mstatus[3];
          csr_wdata[3] = 1'b0;
        end
        S_JUMP: begin
          stall = 1'b1; pc_redirect = 1'b1; redirect_pc = jump_pc;
        end
        S_RET: begin
          stall = 1'b1; csr_we = 1'b1; csr_waddr = ADDR_MSTATUS;
          csr_wdata    = mstatus;
          csr_wdata[3] = mstatus[7];
          csr_wdata[7] = 1'b1;
        end
        S_RJUMP: begin
          stall = 1'b1; pc_redirect = 1'b1; redirect_pc = mepc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed self-checking bench for trap_sequencer
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, is_ecall, is_mret, ext_irq;
  logic [31:0] pc, mtvec, mepc, mstatus;
  logic        stall, csr_we, pc_redirect, busy;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;

  int total  = 0;
  int passed = 0;

  trap_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .is_ecall(is_ecall),
    .is_mret(is_mret), .ext_irq(ext_irq), .pc(pc), .mtvec(mtvec), .mepc(mepc),
    .mstatus(mstatus), .stall(stall), .csr_we(csr_we), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // {stall, busy, csr_we, pc_redirect, csr_waddr, csr_wdata, redirect_pc}
  logic [79:0] obs;
  assign obs = {stall, busy, csr_we, pc_redirect, csr_waddr, csr_wdata, redirect_pc};

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] IRQ_VEC_TARGET = 32'h0000_022C;
`else
  localparam logic [31:0] IRQ_VEC_TARGET = 32'h0000_0200;
`endif

  task automatic idle_inputs();
    instr_valid = 0; is_ecall = 0; is_mret = 0; ext_irq = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); pc = 32'h100; mtvec = 32'h200; mepc = 0; mstatus = 32'h8;
    instr_valid = 1; is_ecall = 1;
    next_cycle();
    total++; if (obs !== 80'h0) $display("FAIL reset_trigger_masked got %h want %h", obs, 80'h0); else passed++;
    rst = 0; idle_inputs();
    next_cycle();
    total++; if (obs !== 80'h0) $display("FAIL reset_idle got %h want %h", obs, 80'h0); else passed++;
  endtask

  task automatic test_ecall();
    pc = 32'h100; mtvec = 32'h200; mstatus = 32'h8;
    instr_valid = 1; is_ecall = 1; #1;
    total++; if (obs !== {4'b1000, 12'h0, 32'h0, 32'h0}) $display("FAIL ecall_trigger got %h", obs); else passed++;
    next_cycle(); idle_inputs(); #1;
    total++; if (obs !== {4'b1110, 12'h341, 32'h100, 32'h0}) $display("FAIL ecall_epc got %h", obs); else passed++;
    next_cycle();
    total++; if (obs !== {4'b1110, 12'h342, 32'd11, 32'h0}) $display("FAIL ecall_cause got %h", obs); else passed++;
    next_cycle();
    total++; if (obs !== {4'b1110, 12'h300, 32'h80, 32'h0}) $display("FAIL ecall_stat got %h", obs); else passed++;
    next_cycle();
    total++; if (obs !== {4'b1101, 12'h0, 32'h0, 32'h200}) $display("FAIL ecall_jump got %h", obs); else passed++;
    next_cycle();
    total++; if (obs !== 80'h0) $display("FAIL ecall_done got %h want 0", obs); else passed++;
  endtask

  task automatic test_irq();
    pc = 32'h40; mtvec = 32'h201; mstatus = 32'h8;
    instr_valid = 1; ext_irq = 1; #1;
    total++; if (obs !== {4'b1000, 12'h0, 32'h0, 32'h0}) $display("FAIL irq_trigger got %h", obs); else passed++;
    next_cycle(); idle_inputs(); ext_irq = 1; #1;
    total++; if (obs !== {4'b1110, 12'h341, 32'h40, 32'h0}) $display("FAIL irq_epc got %h", obs); else passed++;
    next_cycle();
    total++; if (obs !== {4'b1110, 12'h342, 32'h8000_000B, 32'h0}) $display("FAIL irq_cause got %h", obs); else passed++;
    next_cycle();
    total++; if (obs !== {4'b1110, 12'h300, 32'h80, 32'h0}) $display("FAIL irq_stat got %h", obs); else passed++;
    next_cycle();
    total++; if (obs !== {4'b1101, 12'h0, 32'h0, IRQ_VEC_TARGET}) $display("FAIL irq_jump got %h want %h", redirect_pc, IRQ_VEC_TARGET); else passed++;
    // MIE now clear: a pending interrupt must not re-enter
    next_cycle(); mstatus = 32'h80; instr_valid = 1; #1;
    total++; if (obs !== 80'h0) $display("FAIL irq_masked got %h want 0", obs); else passed++;
    next_cycle(); idle_inputs(); #1;
    total++; if (busy !== 1'b0) $display("FAIL irq_masked_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_ecall_vectored_base();
    pc = 32'h10; mtvec = 32'h201; mstatus = 32'h8;
    instr_valid = 1; is_ecall = 1;
    next_cycle(); idle_inputs();
    next_cycle(); next_cycle(); next_cycle();
    total++; if (obs !== {4'b1101, 12'h0, 32'h0, 32'h200}) $display("FAIL ecall_vec_base got %h want 200", redirect_pc); else passed++;
    next_cycle();
  endtask

  task automatic test_mret();
    mepc = 32'h104; mstatus = 32'h80;
    instr_valid = 1; is_mret = 1; #1;
    total++; if (obs !== {4'b1000, 12'h0, 32'h0, 32'h0}) $display("FAIL mret_trigger got %h", obs); else passed++;
    next_cycle(); idle_inputs(); #1;
    total++; if (obs !== {4'b1110, 12'h300, 32'h88, 32'h0}) $display("FAIL mret_stat got %h", obs); else passed++;
    next_cycle();
    total++; if (obs !== {4'b1101, 12'h0, 32'h0, 32'h104}) $display("FAIL mret_jump got %h", obs); else passed++;
    next_cycle();
    total++; if (obs !== 80'h0) $display("FAIL mret_done got %h want 0", obs); else passed++;
  endtask

  task automatic test_irq_over_ecall();
    pc = 32'h80; mtvec = 32'h200; mstatus = 32'h8;
    instr_valid = 1; is_ecall = 1; ext_irq = 1;
    next_cycle(); idle_inputs(); #1;
    total++; if (obs !== {4'b1110, 12'h341, 32'h80, 32'h0}) $display("FAIL prio_epc got %h", obs); else passed++;
    next_cycle();
    total++; if (obs !== {4'b1110, 12'h342, 32'h8000_000B, 32'h0}) $display("FAIL prio_cause got %h", obs); else passed++;
    next_cycle(); next_cycle(); next_cycle();
  endtask

  task automatic test_back_to_back();
    pc = 32'h300; mtvec = 32'h400; mstatus = 32'h8; mepc = 32'h304;
    instr_valid = 1; is_ecall = 1;
    next_cycle(); idle_inputs();
    next_cycle(); next_cycle(); next_cycle();
    // JUMP cycle; next cycle is IDLE and takes an mret straight away
    next_cycle(); mstatus = 32'h80; instr_valid = 1; is_mret = 1; #1;
    total++; if (obs !== {4'b1000, 12'h0, 32'h0, 32'h0}) $display("FAIL b2b_trigger got %h", obs); else passed++;
    next_cycle(); idle_inputs(); #1;
    total++; if (obs !== {4'b1110, 12'h300, 32'h88, 32'h0}) $display("FAIL b2b_ret got %h", obs); else passed++;
    next_cycle();
    total++; if (obs !== {4'b1101, 12'h0, 32'h0, 32'h304}) $display("FAIL b2b_rjump got %h", obs); else passed++;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    pc = 32'h500; mtvec = 32'h200; mstatus = 32'h8;
    instr_valid = 1; is_ecall = 1;
    next_cycle(); idle_inputs();
    next_cycle();
    total++; if (obs !== {4'b1110, 12'h342, 32'd11, 32'h0}) $display("FAIL mid_cause got %h", obs); else passed++;
    #2 rst = 1; #1;
    total++; if ({stall, busy, csr_we, pc_redirect} !== 4'b0000) $display("FAIL mid_abort got %b want 0000", {stall, busy, csr_we, pc_redirect}); else passed++;
    next_cycle(); rst = 0;
    next_cycle();
    total++; if (obs !== 80'h0) $display("FAIL mid_after got %h want 0", obs); else passed++;
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_irq();
    test_ecall_vectored_base();
    test_mret();
    test_irq_over_ecall();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
